// File: rtl/input_stream_packer_pkg.sv
// Shared constants for the pad-word packer feeding the SNN wrapper stream.
// Beat and sample geometry must track the wrapper's streaming parameters.
package input_stream_packer_pkg;

   localparam int PAD_WIDTH        = 11;
   localparam int LANES            = 6;
   localparam int OUT_WIDTH        = PAD_WIDTH * LANES;
   localparam int FIFO_DEPTH       = 4;
   localparam int FIFO_PTR_WIDTH   = 2;
   localparam int BEATS_PER_SAMPLE = 15;
   localparam int BEAT_CNT_WIDTH   = 4;
   localparam int LANE_CNT_WIDTH   = 3;

   typedef logic [OUT_WIDTH-1:0] beat_t;

endpackage

// File: rtl/input_stream_packer_sync_fifo_beat.sv
// Small synchronous beat FIFO; occupancy count separates full from empty.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo_beat #(
   parameter int WIDTH     = 66,
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic [WIDTH-1:0]     push_data_i,
   input  logic                 pop_i,
   output logic [WIDTH-1:0]     pop_data_o,
   output logic [PTR_WIDTH:0]   level_o
);

   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH:0]   LVL_ONE = (PTR_WIDTH+1)'(1);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [WIDTH-1:0]     mem_d [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   level_q, level_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         mem_d    = '{default: '0};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign level_o    = level_q;

endmodule

// File: rtl/input_stream_packer.sv
// Packs pad-rate words into 66-bit beats, buffers them, and issues them
// to the SNN wrapper under its registered ready, framing 15-beat samples.
module input_stream_packer
   import input_stream_packer_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush_i,
   input  logic                      pad_valid_i,
   input  logic [PAD_WIDTH-1:0]      pad_data_i,
   output logic                      pad_ready_o,
   output logic                      stream_valid_o,
   output logic [OUT_WIDTH-1:0]      stream_data_o,
   input  logic                      stream_ready_i,
   output logic                      sample_done_o,
   output logic [BEAT_CNT_WIDTH-1:0] beat_count_o,
   output logic [FIFO_PTR_WIDTH:0]   fifo_level_o,
   output logic                      overflow_o
);

   localparam logic [LANE_CNT_WIDTH-1:0] LANE_LAST =
      LANE_CNT_WIDTH'(LANES - 1);
   localparam logic [LANE_CNT_WIDTH-1:0] LANE_ONE =
      LANE_CNT_WIDTH'(1);
   localparam logic [FIFO_PTR_WIDTH:0] LEVEL_FULL =
      (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_LAST =
      BEAT_CNT_WIDTH'(BEATS_PER_SAMPLE - 1);
   localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE =
      BEAT_CNT_WIDTH'(1);

   logic [LANE_CNT_WIDTH-1:0] lane_cnt_q, lane_cnt_d;
   beat_t                     beat_buf_q, beat_buf_d;
   logic                      stream_valid_q, stream_valid_d;
   beat_t                     stream_data_q, stream_data_d;
   logic                      sample_done_q, sample_done_d;
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                      overflow_q, overflow_d;

   logic                      accept;
   logic                      push;
   logic                      pop;
   beat_t                     push_data;
   beat_t                     fifo_head;
   logic [FIFO_PTR_WIDTH:0]   fifo_level;

   // Only the last lane can be stalled, so ready never depends on the sink.
   assign pad_ready_o = (lane_cnt_q != LANE_LAST) ||
                        (fifo_level < LEVEL_FULL);
   assign accept      = pad_valid_i && pad_ready_o;
   assign push        = accept && (lane_cnt_q == LANE_LAST) && !flush_i;
   assign pop         = (fifo_level != '0) && stream_ready_i && !flush_i;
   assign push_data   = {pad_data_i,
                         beat_buf_q[OUT_WIDTH-PAD_WIDTH-1:0]};

   sync_fifo_beat #(
      .WIDTH     (OUT_WIDTH),
      .DEPTH     (FIFO_DEPTH),
      .PTR_WIDTH (FIFO_PTR_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .pop_data_o  (fifo_head),
      .level_o     (fifo_level)
   );

   always_comb begin
      lane_cnt_d     = lane_cnt_q;
      beat_buf_d     = beat_buf_q;
      stream_valid_d = 1'b0;
      stream_data_d  = stream_data_q;
      sample_done_d  = 1'b0;
      beat_cnt_d     = beat_cnt_q;
      overflow_d     = overflow_q;
      if (flush_i) begin
         lane_cnt_d    = '0;
         beat_buf_d    = '0;
         stream_data_d = '0;
         beat_cnt_d    = '0;
         overflow_d    = 1'b0;
      end else begin
         if (accept) begin
            beat_buf_d[lane_cnt_q*PAD_WIDTH +: PAD_WIDTH] = pad_data_i;
            lane_cnt_d = (lane_cnt_q == LANE_LAST) ? '0
                       : lane_cnt_q + LANE_ONE;
         end
         if (pad_valid_i && !pad_ready_o) begin
            overflow_d = 1'b1;
         end
         if (pop) begin
            stream_valid_d = 1'b1;
            stream_data_d  = fifo_head;
            sample_done_d  = (beat_cnt_q == BEAT_LAST);
            beat_cnt_d     = (beat_cnt_q == BEAT_LAST) ? '0
                           : beat_cnt_q + BEAT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_cnt_q     <= '0;
         beat_buf_q     <= '0;
         stream_valid_q <= 1'b0;
         stream_data_q  <= '0;
         sample_done_q  <= 1'b0;
         beat_cnt_q     <= '0;
         overflow_q     <= 1'b0;
      end else begin
         lane_cnt_q     <= lane_cnt_d;
         beat_buf_q     <= beat_buf_d;
         stream_valid_q <= stream_valid_d;
         stream_data_q  <= stream_data_d;
         sample_done_q  <= sample_done_d;
         beat_cnt_q     <= beat_cnt_d;
         overflow_q     <= overflow_d;
      end
   end

   assign stream_valid_o = stream_valid_q;
   assign stream_data_o  = stream_data_q;
   assign sample_done_o  = sample_done_q;
   assign beat_count_o   = beat_cnt_q;
   assign fifo_level_o   = fifo_level;
   assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_input_stream_packer.sv
// Self-checking bench for input_stream_packer: vector table plus a
// cycle model with a scoreboard queue of expected beats.
module tb_input_stream_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush_i;
   logic        pad_valid_i;
   logic [10:0] pad_data_i;
   logic        pad_ready_o;
   logic        stream_valid_o;
   logic [65:0] stream_data_o;
   logic        stream_ready_i;
   logic        sample_done_o;
   logic [3:0]  beat_count_o;
   logic [2:0]  fifo_level_o;
   logic        overflow_o;

   input_stream_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush_i        (flush_i),
      .pad_valid_i    (pad_valid_i),
      .pad_data_i     (pad_data_i),
      .pad_ready_o    (pad_ready_o),
      .stream_valid_o (stream_valid_o),
      .stream_data_o  (stream_data_o),
      .stream_ready_i (stream_ready_i),
      .sample_done_o  (sample_done_o),
      .beat_count_o   (beat_count_o),
      .fifo_level_o   (fifo_level_o),
      .overflow_o     (overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] w [6];
      logic [65:0] exp;
   } vec_t;

   vec_t        tab [4];
   int          checks   = 0;
   int          failures = 0;
   int          m_lane, m_lvl, m_idx;
   bit          m_ovf;
   logic [65:0] m_beat;
   logic [65:0] exp_q [$];
   logic [65:0] tab_exp;
   bit          use_tab;
   logic [65:0] held;
   int          wn = 0;

   task automatic chk(input string name, input logic [65:0] act,
                      input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_lane = 0;
      m_lvl  = 0;
      m_idx  = 0;
      m_ovf  = 1'b0;
      m_beat = '0;
      exp_q.delete();
   endtask

   task automatic tick();
      bit rdy, acc, pop, ovs;
      logic [65:0] e;
      rdy = (m_lane != 5) || (m_lvl < 4);
      chk("pad_ready", 66'(pad_ready_o), 66'(rdy));
      acc = pad_valid_i && rdy;
      ovs = pad_valid_i && !rdy;
      pop = (m_lvl > 0) && stream_ready_i && !flush_i;
      @(posedge clk);
      #1;
      if (flush_i) begin
         model_clear();
      end else begin
         if (acc) begin
            m_beat[m_lane*11 +: 11] = pad_data_i;
            if (m_lane == 5) begin
               exp_q.push_back(use_tab ? tab_exp : m_beat);
               m_lane = 0;
               m_lvl++;
            end else begin
               m_lane++;
            end
         end
         if (pop) m_lvl--;
         if (ovs) m_ovf = 1'b1;
      end
      chk("stream_valid", 66'(stream_valid_o), 66'(pop));
      if (pop) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=%0h required=none",
                     stream_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("stream_data", stream_data_o, e);
         end
         chk("sample_done", 66'(sample_done_o), 66'(m_idx == 14));
         m_idx = (m_idx + 1) % 15;
      end else begin
         chk("sample_done_idle", 66'(sample_done_o), 66'(0));
      end
      chk("beat_count", 66'(beat_count_o), 66'(m_idx));
      chk("fifo_level", 66'(fifo_level_o), 66'(m_lvl));
      chk("overflow", 66'(overflow_o), 66'(m_ovf));
   endtask

   task automatic drive(input bit v, input logic [10:0] d, input bit r);
      pad_valid_i    = v;
      pad_data_i     = d;
      stream_ready_i = r;
      tick();
   endtask

   task automatic words(input int n, input bit r);
      for (int i = 0; i < n; i++) begin
         wn++;
         drive(1'b1, 11'(wn * 73 + 5), r);
      end
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) drive(1'b0, 11'h0, r);
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      drive(1'b0, 11'h0, 1'b1);
      flush_i = 1'b0;
   endtask

   initial begin
      tab[0].w   = '{11'h001, 11'h002, 11'h003, 11'h004, 11'h005, 11'h006};
      tab[0].exp = {11'h006, 11'h005, 11'h004, 11'h003, 11'h002, 11'h001};
      tab[1].w   = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
      tab[1].exp = {66{1'b1}};
      tab[2].w   = '{11'h555, 11'h2AA, 11'h555, 11'h2AA, 11'h555, 11'h2AA};
      tab[2].exp = {11'h2AA, 11'h555, 11'h2AA, 11'h555, 11'h2AA, 11'h555};
      tab[3].w   = '{11'h400, 11'h000, 11'h000, 11'h000, 11'h000, 11'h001};
      tab[3].exp = {11'h001, 11'h000, 11'h000, 11'h000, 11'h000, 11'h400};

      reset_n        = 1'b0;
      flush_i        = 1'b0;
      pad_valid_i    = 1'b0;
      pad_data_i     = '0;
      stream_ready_i = 1'b0;
      use_tab        = 1'b0;
      tab_exp        = '0;
      model_clear();
      #12;
      chk("rst_pad_ready", 66'(pad_ready_o), 66'(1));
      chk("rst_valid", 66'(stream_valid_o), 66'(0));
      chk("rst_data", stream_data_o, 66'(0));
      chk("rst_done", 66'(sample_done_o), 66'(0));
      chk("rst_beat", 66'(beat_count_o), 66'(0));
      chk("rst_level", 66'(fifo_level_o), 66'(0));
      chk("rst_ovf", 66'(overflow_o), 66'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // packing vectors, ready held high
      use_tab = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tab_exp = tab[i].exp;
         for (int k = 0; k < 6; k++) drive(1'b1, tab[i].w[k], 1'b1);
         idle(2, 1'b1);
      end
      use_tab = 1'b0;

      // backpressure fill then drain
      words(29, 1'b0);
      chk("bp_level_full", 66'(fifo_level_o), 66'(4));
      chk("bp_ready_low", 66'(pad_ready_o), 66'(0));
      idle(4, 1'b1);
      chk("bp_ready_back", 66'(pad_ready_o), 66'(1));
      words(1, 1'b1);
      idle(2, 1'b1);

      // full sample framing
      do_flush();
      words(90, 1'b1);
      idle(2, 1'b1);
      chk("frame_wrap", 66'(beat_count_o), 66'(0));

      // overflow with fifo full and last lane pending
      words(29, 1'b0);
      held = stream_data_o;
      drive(1'b1, 11'h7AB, 1'b0);
      idle(2, 1'b0);
      chk("ovf_sticky", 66'(overflow_o), 66'(1));
      chk("ovf_level", 66'(fifo_level_o), 66'(4));
      chk("ovf_data_hold", stream_data_o, held);
      idle(4, 1'b1);

      // flush mid-beat with two beats queued
      words(10, 1'b0);
      do_flush();
      words(6, 1'b1);
      idle(2, 1'b1);

      // async reset mid-cycle
      words(9, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 66'(stream_valid_o), 66'(0));
      chk("arst_data", stream_data_o, 66'(0));
      chk("arst_level", 66'(fifo_level_o), 66'(0));
      chk("arst_beat", 66'(beat_count_o), 66'(0));
      chk("arst_ready", 66'(pad_ready_o), 66'(1));
      model_clear();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      words(6, 1'b1);
      idle(2, 1'b1);

      // ready toggling with three beats queued
      words(18, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 11'h0, (i % 2) == 0);
      idle(2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
